// File: rtl/count_pkg.sv
// Shared definitions for the count checker: state encoding and default sizes.
// The counter block takes its WIDTH default from DEF_WIDTH so both stay in step.
package count_pkg;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_ERR_W       = 8;
    localparam int DEF_LOCK_CYCLES = 2;

    // Wide enough for LOCK_CYCLES up to 15
    localparam int GOOD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [ERR_W-1:0] count
);

    logic [ERR_W-1:0] count_reg;
    logic             at_max;

    assign at_max = &count_reg;
    assign count  = count_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && !at_max) begin
            count_reg <= count_reg + ERR_W'(1);
        end
    end

endmodule

// File: rtl/count_checker.sv
// Checks that count_in advances by +1 (mod 2^WIDTH) every enabled cycle, locks onto
// the sequence, and reports breaks, legal wraps and a saturating error count.
module count_checker
    import count_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int ERR_W       = DEF_ERR_W,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] count_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             mismatch,
    output logic             wrap,
    output logic [WIDTH-1:0] expected,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [GOOD_W-1:0] LOCK_TARGET = GOOD_W'(LOCK_CYCLES);
    localparam logic [WIDTH-1:0]  MAX_VAL     = '1;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  prev_reg, prev_next;
    logic              prev_valid_reg, prev_valid_next;
    logic [GOOD_W-1:0] good_cnt_reg, good_cnt_next;
    logic              locked_reg, locked_next;
    logic              mismatch_reg, mismatch_next;
    logic              wrap_reg, wrap_next;
    logic [WIDTH-1:0]  expected_reg, expected_next;

    logic [WIDTH-1:0]  prev_inc;
    logic [GOOD_W-1:0] good_inc;
    logic              step_ok;
    logic              err_inc;

    assign prev_inc = prev_reg + WIDTH'(1);
    assign good_inc = good_cnt_reg + GOOD_W'(1);
    assign step_ok  = (count_in == prev_inc);

    always_comb begin
        state_next      = state_reg;
        prev_next       = prev_reg;
        prev_valid_next = prev_valid_reg;
        good_cnt_next   = good_cnt_reg;
        locked_next     = 1'b0;
        mismatch_next   = 1'b0;
        wrap_next       = 1'b0;
        err_inc         = 1'b0;

        if (!enable) begin
            // Dropping enable forgets the sequence; a full re-acquire follows
            state_next      = ST_IDLE;
            prev_valid_next = 1'b0;
            good_cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next      = ST_ACQ;
                    prev_next       = count_in;
                    prev_valid_next = 1'b1;
                    good_cnt_next   = '0;
                end
                ST_ACQ: begin
                    prev_next = count_in;
                    if (step_ok) begin
                        if (good_inc == LOCK_TARGET) begin
                            state_next    = ST_LOCK;
                            locked_next   = 1'b1;
                            good_cnt_next = '0;
                        end else begin
                            good_cnt_next = good_inc;
                        end
                    end else begin
                        good_cnt_next = '0;
                    end
                end
                ST_LOCK: begin
                    prev_next = count_in;
                    if (count_in == expected_reg) begin
                        locked_next = 1'b1;
                        wrap_next   = (prev_reg == MAX_VAL) && (count_in == '0);
                    end else begin
                        // Any break, including an upstream reset to 0, is reported once
                        mismatch_next = 1'b1;
                        err_inc       = 1'b1;
                        state_next    = ST_ACQ;
                        good_cnt_next = '0;
                    end
                end
                default: begin
                    state_next      = ST_IDLE;
                    prev_valid_next = 1'b0;
                    good_cnt_next   = '0;
                end
            endcase
        end

        expected_next = prev_valid_next ? (prev_next + WIDTH'(1)) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            prev_reg       <= '0;
            prev_valid_reg <= 1'b0;
            good_cnt_reg   <= '0;
            locked_reg     <= 1'b0;
            mismatch_reg   <= 1'b0;
            wrap_reg       <= 1'b0;
            expected_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            prev_reg       <= prev_next;
            prev_valid_reg <= prev_valid_next;
            good_cnt_reg   <= good_cnt_next;
            locked_reg     <= locked_next;
            mismatch_reg   <= mismatch_next;
            wrap_reg       <= wrap_next;
            expected_reg   <= expected_next;
        end
    end

    sat_counter #(
        .ERR_W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .clr   (clr_err),
        .count (err_count)
    );

    assign locked   = locked_reg;
    assign mismatch = mismatch_reg;
    assign wrap     = wrap_reg;
    assign expected = expected_reg;

endmodule

// File: tb/tb_count_checker.sv
// Self-checking bench for count_checker: directed scenarios then random traffic,
// compared against a sequence-level reference model for ERR_W=8 and ERR_W=2 instances.
module tb_count_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] count_in = 4'd0;
    logic       clr_err = 1'b0;

    logic       locked8, mismatch8, wrap8;
    logic [3:0] expected8;
    logic [7:0] err8;
    logic       locked2, mismatch2, wrap2;
    logic [3:0] expected2;
    logic [1:0] err2;

    int tests = 0;
    int failed = 0;

    // Reference model state
    bit m_have = 0;
    int m_last = 0;
    int m_streak = 0;
    bit m_locked = 0;
    bit m_mism = 0;
    bit m_wrap = 0;
    int m_exp = 0;
    int m_err8 = 0;
    int m_err2 = 0;

    int cur;

    always #5 clk = ~clk;

    count_checker #(.WIDTH(4), .ERR_W(8), .LOCK_CYCLES(2)) dut8 (
        .clk(clk), .reset(reset), .enable(enable), .count_in(count_in), .clr_err(clr_err),
        .locked(locked8), .mismatch(mismatch8), .wrap(wrap8), .expected(expected8),
        .err_count(err8)
    );

    count_checker #(.WIDTH(4), .ERR_W(2), .LOCK_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .count_in(count_in), .clr_err(clr_err),
        .locked(locked2), .mismatch(mismatch2), .wrap(wrap2), .expected(expected2),
        .err_count(err2)
    );

    function automatic int nx(input int v);
        return (v + 1) % 16;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sequence rules applied to one sampled edge
    task automatic model(input bit rn, input bit en, input int cin, input bit clr);
        m_mism = 0;
        m_wrap = 0;
        if (!rn) begin
            m_have = 0; m_last = 0; m_streak = 0; m_locked = 0;
            m_err8 = 0; m_err2 = 0;
        end else begin
            if (!en) begin
                m_have = 0; m_locked = 0; m_streak = 0;
            end else if (!m_have) begin
                m_have = 1; m_last = cin; m_streak = 0; m_locked = 0;
            end else if (m_locked) begin
                if (cin == nx(m_last)) begin
                    m_wrap = (m_last == 15) && (cin == 0);
                end else begin
                    m_mism = 1;
                    m_locked = 0;
                    m_streak = 0;
                    if (m_err8 < 255) m_err8++;
                    if (m_err2 < 3) m_err2++;
                end
                m_last = cin;
            end else begin
                m_streak = (cin == nx(m_last)) ? m_streak + 1 : 0;
                if (m_streak == 2) begin
                    m_locked = 1;
                    m_streak = 0;
                end
                m_last = cin;
            end
            if (clr) begin
                m_err8 = 0;
                m_err2 = 0;
            end
        end
        m_exp = m_have ? nx(m_last) : 0;
    endtask

    task automatic step(input bit rn, input bit en, input int cin, input bit clr);
        reset    = rn;
        enable   = en;
        count_in = 4'(cin);
        clr_err  = clr;
        @(posedge clk);
        #1;
        model(rn, en, cin, clr);
        check("locked8",   32'(locked8),   32'(m_locked));
        check("mismatch8", 32'(mismatch8), 32'(m_mism));
        check("wrap8",     32'(wrap8),     32'(m_wrap));
        check("expected8", 32'(expected8), 32'(m_exp));
        check("err8",      32'(err8),      32'(m_err8));
        check("locked2",   32'(locked2),   32'(m_locked));
        check("mismatch2", 32'(mismatch2), 32'(m_mism));
        check("err2",      32'(err2),      32'(m_err2));
        $display("[TB] t=%0t rst=%0b en=%0b cin=%0d clr=%0b -> lock=%0b mis=%0b wrap=%0b exp=%0d err8=%0d err2=%0d",
                 $time, rn, en, cin, clr, locked8, mismatch8, wrap8, expected8, err8, err2);
    endtask

    initial begin
        // Reset held for two cycles with a nonzero count present
        step(0, 0, 7, 0);
        step(0, 0, 7, 0);
        check("rst_locked", 32'(locked8), 32'd0);
        check("rst_expected", 32'(expected8), 32'd0);
        check("rst_err", 32'(err8), 32'd0);
        check("rst_pulses", 32'({mismatch8, wrap8}), 32'd0);

        // Acquire on 0,1,2,3
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        check("acq_not_locked", 32'(locked8), 32'd0);
        step(1, 1, 2, 0);
        check("lock_after_2", 32'(locked8), 32'd1);
        step(1, 1, 3, 0);
        check("expected_4", 32'(expected8), 32'd4);

        // Legal wrap 15 -> 0
        for (int v = 4; v <= 15; v++) step(1, 1, v, 0);
        step(1, 1, 0, 0);
        check("wrap_pulse", 32'(wrap8), 32'd1);
        check("wrap_no_mis", 32'(mismatch8), 32'd0);
        step(1, 1, 1, 0);
        check("wrap_one_cycle", 32'(wrap8), 32'd0);

        // Break 6 -> 9, re-lock on 10,11
        for (int v = 2; v <= 6; v++) step(1, 1, v, 0);
        step(1, 1, 9, 0);
        check("break_mis", 32'(mismatch8), 32'd1);
        check("break_err", 32'(err8), 32'd1);
        check("break_unlock", 32'(locked8), 32'd0);
        step(1, 1, 10, 0);
        check("break_mis_once", 32'(mismatch8), 32'd0);
        check("break_still_unlocked", 32'(locked8), 32'd0);
        step(1, 1, 11, 0);
        check("break_relock", 32'(locked8), 32'd1);

        // Upstream counter reset: locked at 8, then 0,1,2
        for (int v = 12; v <= 15; v++) step(1, 1, v, 0);
        for (int v = 0; v <= 8; v++) step(1, 1, v, 0);
        step(1, 1, 0, 0);
        check("upreset_mis", 32'(mismatch8), 32'd1);
        check("upreset_err", 32'(err8), 32'd2);
        step(1, 1, 1, 0);
        step(1, 1, 2, 0);
        check("upreset_relock", 32'(locked8), 32'd1);

        // Five more breaks: ERR_W=2 saturates at 3
        cur = 2;
        for (int k = 0; k < 5; k++) begin
            cur = (cur + 7) % 16;
            step(1, 1, cur, 0);
            cur = nx(cur); step(1, 1, cur, 0);
            cur = nx(cur); step(1, 1, cur, 0);
        end
        check("sat_err2", 32'(err2), 32'd3);
        check("sat_err8", 32'(err8), 32'd7);

        // Clear together with a mismatch: clear wins, pulse still fires
        cur = (cur + 4) % 16;
        step(1, 1, cur, 1);
        check("clr_mis", 32'(mismatch8), 32'd1);
        check("clr_err8", 32'(err8), 32'd0);
        check("clr_err2", 32'(err2), 32'd0);
        cur = nx(cur); step(1, 1, cur, 0);
        cur = nx(cur); step(1, 1, cur, 0);

        // One-cycle reset while locked
        cur = nx(cur); step(0, 1, cur, 0);
        check("midrst_unlock", 32'(locked8), 32'd0);
        check("midrst_expected", 32'(expected8), 32'd0);
        cur = nx(cur); step(1, 1, cur, 0);
        check("midrst_acq", 32'(locked8), 32'd0);
        cur = nx(cur); step(1, 1, cur, 0);
        cur = nx(cur); step(1, 1, cur, 0);
        check("midrst_relock", 32'(locked8), 32'd1);

        // Enable low drops lock and zeroes expected
        cur = nx(cur); step(1, 0, cur, 0);
        check("dis_unlock", 32'(locked8), 32'd0);
        check("dis_expected", 32'(expected8), 32'd0);

        // Random traffic: mostly clean increments with occasional faults
        for (int i = 0; i < 400; i++) begin
            bit rn, en, clr;
            rn  = ($urandom_range(0, 99) != 0);
            en  = ($urandom_range(0, 19) != 0);
            clr = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 11) == 0) cur = $urandom_range(0, 15);
            else cur = nx(cur);
            step(rn, en, cur, clr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/count_checker.md
Name: count_checker

Overview:
- Receive-side monitor for the 4-bit free-running counter. It samples the counter value every clock and checks that it advances by +1 per cycle, modulo 2^WIDTH.
- It locks onto the incoming sequence and flags each break in the sequence as a one-cycle mismatch pulse. It also keeps a saturating error count and pulses on each legal wrap from max to 0.
- It sits beside the counter in the same clock domain, as its consumer/checker.

Parameters:
- WIDTH, 4, width of the observed count value.
- ERR_W, 8, width of the error counter.
- LOCK_CYCLES, 2, number of consecutive correct increments required to enter LOCKED (range 1..15).

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
- enable  input  1  1 = check this cycle; 0 = checker idles and holds its error count.
- count_in  input  WIDTH  observed counter value.
- clr_err  input  1  synchronous clear of err_count.
- locked  output  1  1 while in LOCKED.
- mismatch  output  1  one-cycle pulse on a sequence break detected while LOCKED.
- wrap  output  1  one-cycle pulse when a correct max->0 transition is seen while LOCKED.
- expected  output  WIDTH  value expected on the next cycle (prev+1 mod 2^WIDTH).
- err_count  output  ERR_W  saturating mismatch count.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE; locked=0, mismatch=0, wrap=0, expected=0, err_count=0.
  - Internal prev, prev_valid and good_cnt are cleared.
  - Reset overrides all other inputs. Reset in mid-operation drops lock on the next edge.
- Outputs are registered: each output reflects the count_in sampled at the previous edge (1-cycle latency).
- States: IDLE, ACQUIRE, LOCKED.
- IDLE:
  - enable=1 -> ACQUIRE, capturing prev=count_in and setting prev_valid=1, good_cnt=0.
  - enable=0 -> stay in IDLE.
- ACQUIRE, each enabled cycle:
  - If count_in==prev+1 (mod 2^WIDTH), good_cnt++. Otherwise good_cnt=0.
  - prev<=count_in in both cases.
  - When the increment makes good_cnt==LOCK_CYCLES -> LOCKED, with locked=1 from the next cycle.
  - No mismatch pulses or err_count changes occur in ACQUIRE.
- LOCKED, each enabled cycle, compare count_in with expected:
  - Equal: stay in LOCKED. wrap=1 if prev==2^WIDTH-1 and count_in==0.
  - Not equal: mismatch=1 for one cycle; err_count increments (saturating at 2^ERR_W-1); locked=0; state -> ACQUIRE with good_cnt=0 and prev=count_in.
  - A jump to 0 that is not from max counts as a mismatch. An upstream counter reset is therefore reported once, then the checker re-acquires.
- expected is always prev+1 mod 2^WIDTH, truncated to WIDTH bits. In IDLE it holds 0.
- enable=0 in any state:
  - Next state IDLE; locked=0; pulses 0; prev_valid=0; err_count held.
  - Re-enabling requires a full re-acquire.
- clr_err=1:
  - err_count=0 next cycle.
  - If a mismatch occurs in the same cycle, clear wins: err_count=0 and mismatch still pulses.
- mismatch and wrap are mutually exclusive by construction.

Decomposition:
- Shared package count_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_ACQ=2'd1, ST_LOCK=2'd2;
  - default WIDTH=4.
  - The counter block reuses the WIDTH default from this package.
- One natural sub-module: sat_counter (parameter ERR_W; inputs inc and clr; clear has priority). It is used for err_count.
- The FSM and comparator stay in count_checker.

Test Plan:
- Hold reset=0 for 2 cycles with count_in=7 -> all outputs 0, err_count=0. Release, enable=1, drive 0,1,2,3 -> locked=1 by the edge after the sample 2 (LOCK_CYCLES=2); expected=4 after sample 3.
- Locked, drive ...13,14,15,0,1 -> wrap=1 exactly one cycle after the 0 is sampled; mismatch stays 0.
- Locked at 5, drive 5,6,9,10,11 -> one mismatch pulse one cycle after the 9 is sampled; err_count=1; locked=0 for 2 cycles, then re-locks after 10,11.
- Locked at 8, drive 0 (upstream reset), then 1,2 -> single mismatch, err_count increments by 1, re-lock after 1,2.
- ERR_W=2 configuration, force 5 mismatches -> err_count saturates at 3. Assert clr_err together with a mismatch -> err_count=0 and mismatch=1.
- Locked, then reset=0 for 1 cycle, then count_in continues with a correct increment -> locked=0 and state IDLE for 1 cycle, then ACQUIRE; err_count=0.
